// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_arb_pkg: FSM state encoding and channel-index width helper for fifo_rr_arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2,
        WR   = 2'd3
    } state_t;

    function automatic int ch_w(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first request found upward from ptr+1 modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Walk from farthest to nearest so the nearest requester is the last assignment.
    always_comb begin
        idx = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of NUM_CH input FIFOs into one tagged output FIFO.
// Define FIFO_ARB_BURST_EN to let a grant forward up to MAX_BURST words back to back.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 4,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        in_empty,
    output logic [NUM_CH-1:0]        in_rd,
    input  logic [NUM_CH*DATA_W-1:0] in_din,
    input  logic                     out_full,
    output logic                     out_wr,
    output logic [DATA_W-1:0]        out_dout,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    output logic [31:0]              word_count
);

    state_t state, next;
    logic [CH_W-1:0] g, rr_ptr, pick_idx;
    logic [NUM_CH-1:0] req;
    logic pick_valid, more;

    assign req = ~in_empty & ch_mask;

    rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef FIFO_ARB_BURST_EN
    logic [7:0] burst_cnt;

    assign more = req[g] && enable && burst_cnt < 8'(MAX_BURST - 1);

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            burst_cnt <= '0;
        else if (out_wr)
            burst_cnt <= more ? burst_cnt + 8'd1 : 8'd0;
`else
    assign more = 1'b0;
`endif

    assign out_wr = state == WR && !out_full;

    always_comb begin
        next = state;
        next = state == IDLE ? (enable && pick_valid ? RD : IDLE) :
               state == RD   ? LAT :
               state == LAT  ? WR :
               out_full      ? WR :
               more          ? RD : IDLE;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= next;

    // in_rd is registered off the next state so the strobe is a clean one-cycle pulse.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            g          <= '0;
            rr_ptr     <= CH_W'(NUM_CH - 1);
            in_rd      <= '0;
            busy       <= 1'b0;
            out_dout   <= '0;
            out_ch     <= '0;
            word_count <= '0;
        end else begin
            busy  <= next != IDLE;
            in_rd <= next == RD ? NUM_CH'(1) << (state == IDLE ? pick_idx : g) : '0;
            if (state == IDLE)
                g <= pick_idx;
            if (state == LAT) begin
                out_dout <= in_din[int'(g) * DATA_W +: DATA_W];
                out_ch   <= g;
            end
            if (out_wr) begin
                word_count <= word_count + 32'd1;
                if (!more)
                    rr_ptr <= g;
            end
        end

endmodule
